dmem_responder: RTL

Memory-side responder for the RV64 core's data-memory port: accepts one load or store request at a time from the MEM stage, completes it after a fixed programmable latency, and returns formatted read data plus an error flag. It replaces the single-cycle data memory and supplies a `busy` stall signal to the hazard unit, so the pipeline holds while an access is outstanding. Little-endian, byte-addressed, 64-bit words.

---
 rtl/dmem_pkg.sv | 52 +++++
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_load_format.sv | 34 +++
 rtl/dmem_responder.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and decode helpers for the data-memory responder.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W,
        SZ_D
    } size_e;

    function automatic size_e size_of(input logic [2:0] funct3);
        return size_e'(funct3[1:0]);
    endfunction

    // Byte lanes covered by an access of the given size at offset 0.
    function automatic logic [7:0] lane_mask(input size_e sz);
        logic [7:0] m;
        case (sz)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    function automatic logic is_misaligned(input size_e sz, input logic [2:0] off);
        logic r;
        case (sz)
            SZ_B:    r = 1'b0;
            SZ_H:    r = off[0];
            SZ_W:    r = |off[1:0];
            default: r = |off;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage and the data-memory responder.
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_load_format.sv
// Combinational lane logic: load extraction/extension and store shift/byte mask.
module dmem_load_format
    import dmem_pkg::*;
(
    input  logic [63:0] word_i,
    input  logic [63:0] wdata_i,
    input  logic [2:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [63:0] ld_data_o,
    output logic [63:0] st_data_o,
    output logic [7:0]  st_mask_o
);

    logic [63:0] shifted;

    always_comb begin
        shifted   = word_i >> {off_i, 3'b000};
        ld_data_o = '0;
        case (funct3_i)
            F3_B:    ld_data_o = {{56{shifted[7]}},  shifted[7:0]};
            F3_H:    ld_data_o = {{48{shifted[15]}}, shifted[15:0]};
            F3_W:    ld_data_o = {{32{shifted[31]}}, shifted[31:0]};
            F3_D:    ld_data_o = shifted;
            F3_BU:   ld_data_o = {56'd0, shifted[7:0]};
            F3_HU:   ld_data_o = {48'd0, shifted[15:0]};
            F3_WU:   ld_data_o = {32'd0, shifted[31:0]};
            default: ld_data_o = '0;
        endcase
    end

    assign st_data_o = wdata_i << {off_i, 3'b000};
    assign st_mask_o = 8'(lane_mask(size_of(funct3_i)) << off_i);

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: one outstanding load/store, stall via busy.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 512,
    parameter int unsigned LATENCY     = 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus,
    output logic            busy
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [63:0] mem [DEPTH_WORDS];

    logic             act_we;
    logic [63:0]      act_addr, act_wdata;
    logic [2:0]       act_f3;
    logic [IDX_W-1:0] act_idx;
    logic [63:0]      ld_data, st_data;
    logic [7:0]       st_mask;
    logic             bad_f3, misalign, oor, err_c, commit_c, write_c;

    // With LATENCY=1 the commit edge is the accept edge, so take fields straight from the bus.
    always_comb begin
        if (state_q == ST_IDLE) begin
            act_we    = bus.req_we;
            act_addr  = bus.req_addr;
            act_wdata = bus.req_wdata;
            act_f3    = bus.req_funct3;
        end else begin
            act_we    = we_q;
            act_addr  = addr_q;
            act_wdata = wdata_q;
            act_f3    = f3_q;
        end
    end

    assign act_idx  = act_addr[3 +: IDX_W];
    assign bad_f3   = act_we ? act_f3[2] : (act_f3 == 3'b111);
    assign misalign = is_misaligned(size_of(act_f3), act_addr[2:0]);
    assign oor      = act_addr[63:3] >= 61'(DEPTH_WORDS);
    assign err_c    = bad_f3 | misalign | oor;

    dmem_load_format u_fmt (
        .word_i    (mem[act_idx]),
        .wdata_i   (act_wdata),
        .off_i     (act_addr[2:0]),
        .funct3_i  (act_f3),
        .ld_data_o (ld_data),
        .st_data_o (st_data),
        .st_mask_o (st_mask)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        f3_d        = f3_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        err_d       = err_q;
        commit_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    f3_d    = bus.req_funct3;
                    cnt_d   = CNT_LOAD;
                    if (LATENCY == 32'd1) begin
                        state_d  = ST_RESP;
                        commit_c = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Leave on the edge whose decrement reaches zero.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d  = ST_RESP;
                    commit_c = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (commit_c) begin
            rsp_valid_d = 1'b1;
            err_d       = err_c;
            rdata_d     = (err_c || act_we) ? 64'd0 : ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            f3_q        <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            f3_q        <= f3_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Array is never cleared; a reset on the commit edge suppresses the write.
    assign write_c = commit_c & act_we & ~err_c & ~rst;

    always_ff @(posedge clk) begin
        if (write_c) begin
            for (int b = 0; b < 8; b++) begin
                if (st_mask[b]) mem[act_idx][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE) & ~rst;
    assign busy          = (state_q == ST_WAIT) | ((state_q == ST_IDLE) & bus.req_valid & ~rst);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule
